// File: rtl/load_store_unit_if.sv
// Execute/writeback request-response handshake plus the data-memory port of the LSU.
// The unit itself connects through the slave modport.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_fault, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_fault, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage controller: one load/store in flight, alignment/range checks, load extension
// and read-modify-write for sub-word stores against a word-write-only data memory.
module load_store_unit #(
    parameter int unsigned ADDR_BITS = 10
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;

    logic        req_fault;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        req_fault = 1'b0;
        if (bus.req_store) begin
            req_fault = bus.req_funct3 > 3'd2;
        end else begin
            req_fault = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11);
        end
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) req_fault = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_fault = 1'b1;
        if ((bus.req_addr >> ADDR_BITS) != 32'd0) req_fault = 1'b1;
    end

    always_comb begin
        shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        half    = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_ext = {{16{half[15]}}, half};
            3'd4:    load_ext = {24'd0, shifted[7:0]};
            3'd5:    load_ext = {16'd0, half};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // merge_q still holds the store data while in RMW_READ; it is replaced by the merged word.
    always_comb begin
        merged = bus.mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = merge_q[7:0];
        end else if (addr_q[1]) begin
            merged[31:16] = merge_q[15:0];
        end else begin
            merged[15:0] = merge_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        merge_d  = merge_q;
        data_d   = data_q;
        fault_d  = fault_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    merge_d  = bus.req_wdata;
                    data_d   = 32'd0;
                    fault_d  = req_fault;
                    if (req_fault) begin
                        state_d = StResp;
                    end else if (!bus.req_store) begin
                        state_d = StLoad;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRead;
                    end
                end
            end
            StLoad: begin
                data_d  = load_ext;
                state_d = StResp;
            end
            StRmwRead: begin
                merge_d = merged;
                state_d = StWrite;
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            merge_q  <= 32'd0;
            data_q   <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            merge_q  <= merge_d;
            data_q   <= data_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        bus.req_ready  = state_q == StIdle;
        bus.resp_valid = state_q == StResp;
        bus.resp_data  = (state_q == StResp) ? data_q : 32'd0;
        bus.resp_fault = (state_q == StResp) && fault_q;
        bus.mem_re     = (state_q == StLoad) || (state_q == StRmwRead);
        // Gate with rst so a reset asserted mid-WRITE cannot commit on the next edge.
        bus.mem_we     = (state_q == StWrite) && !rst;
        bus.mem_wdata  = (state_q == StWrite) ? merge_q : 32'd0;
        bus.mem_addr   = (state_q == StIdle) ? 32'd0 : {addr_q[31:2], 2'b00};
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random traffic checked against
// a byte-level reference model of a 256-word memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.ADDR_BITS(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] data;
        bit          fault;
        int          lat;
        int          acc;
        int          re_tot;
        int          we_tot;
    } exp_t;

    exp_t        q[$];
    logic [31:0] dmem[256];
    logic [31:0] ref_mem[256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          exp_re = 0;
    int          exp_we = 0;
    int          rr_mode = 0;
    bit          seen = 0;
    bit          chk_idle = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8070_F0A5;
        if (i == 8) return 32'h1122_3344;
        return (32'h9E37_79B9 * (i + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Data memory: combinational read, word write on the edge that ends a mem_we cycle.
    assign bus.mem_rdata = dmem[bus.mem_addr[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we) dmem[bus.mem_addr[9:2]] = bus.mem_wdata;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.mem_re) re_cnt <= re_cnt + 1;
        if (!rst && bus.mem_we) we_cnt <= we_cnt + 1;
    end

    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       bus.resp_ready = 1'b1;
                1:       bus.resp_ready = $urandom_range(0, 3) != 0;
                default: bus.resp_ready = 1'b0;
            endcase
        end
    end

    // Reference model: works on byte lanes of a word array; updates memory for stores.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] d, output bit flt);
        int size;
        int lane;
        logic [31:0] w;
        logic [31:0] mask;
        flt  = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size = 1 << (f3 % 4);
        if (a % size != 0) flt = 1'b1;
        if (a >= 32'd1024) flt = 1'b1;
        d = 32'd0;
        if (flt) return;
        w    = ref_mem[a / 4];
        lane = a % 4;
        if (!st) begin
            if (size == 4) begin
                d = w;
            end else begin
                mask = (32'd1 << (8 * size)) - 1;
                d    = (w >> (8 * lane)) & mask;
                if (f3 < 3'd4 && d[8 * size - 1]) d = d | ~mask;
            end
        end else begin
            for (int i = 0; i < size; i++) w[8 * (lane + i) +: 8] = wd[8 * i +: 8];
            ref_mem[a / 4] = w;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the request handshake edge.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_d);
        int          n = 0;
        exp_t        e;
        logic [31:0] d;
        bit          flt;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got req_ready=0 want 1 (t=%0t)", $time);
            return;
        end
        model(st, f3, a, wd, d, flt);
        if (!flt && (!st || f3 != 3'd2)) exp_re++;
        if (!flt && st) exp_we++;
        e.data   = use_exp ? exp_d : d;
        e.fault  = flt;
        e.lat    = flt ? 1 : ((!st || f3 == 3'd2) ? 2 : 3);
        e.acc    = cyc;
        e.re_tot = exp_re;
        e.we_tot = exp_we;
        q.push_back(e);
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every RESP cycle against the head of the scoreboard, pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen     = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_after_handshake", 32'(bus.req_ready), 1);
                chk_idle = 1'b0;
            end
            if (bus.resp_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 want 0 (t=%0t)", $time);
                end else begin
                    if (!seen) begin
                        check("latency", cyc - q[0].acc, q[0].lat);
                        check("mem_re_count", re_cnt, q[0].re_tot);
                        check("mem_we_count", we_cnt, q[0].we_tot);
                        seen = 1'b1;
                    end
                    check("resp_data", bus.resp_data, q[0].data);
                    check("resp_fault", 32'(bus.resp_fault), 32'(q[0].fault));
                    check("req_ready_busy", 32'(bus.req_ready), 0);
                    check("resp_no_strobe", 32'({bus.mem_we, bus.mem_re}), 0);
                    if (bus.resp_ready) begin
                        void'(q.pop_front());
                        seen     = 1'b0;
                        chk_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int diffs;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        rst = 1'b1;
        #3;
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_fault", 32'(bus.resp_fault), 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_mem_strobes", 32'({bus.mem_we, bus.mem_re}), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1'b0, 3'd0, 32'h11, 32'd0, 1'b1, 32'hFFFF_FFF0);
        issue(1'b0, 3'd4, 32'h11, 32'd0, 1'b1, 32'h0000_00F0);
        issue(1'b0, 3'd1, 32'h12, 32'd0, 1'b1, 32'hFFFF_8070);
        issue(1'b0, 3'd5, 32'h12, 32'd0, 1'b1, 32'h0000_8070);
        issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h8070_F0A5);

        issue(1'b1, 3'd0, 32'h22, 32'h0000_00AB, 1'b1, 32'd0);
        wait_drain();
        check("sb_merge", dmem[8], 32'h11AB_3344);
        issue(1'b1, 3'd1, 32'h20, 32'h0000_BEEF, 1'b1, 32'd0);
        wait_drain();
        check("sh_merge", dmem[8], 32'h11AB_BEEF);

        issue(1'b0, 3'd2, 32'h06, 32'd0, 1'b1, 32'd0);
        issue(1'b1, 3'd1, 32'h03, 32'h1234_5678, 1'b1, 32'd0);
        issue(1'b0, 3'd2, 32'h400, 32'd0, 1'b1, 32'd0);
        issue(1'b0, 3'd3, 32'h10, 32'd0, 1'b1, 32'd0);
        wait_drain();
        check("fault_mem_intact", dmem[0], init_word(0));

        rr_mode = 2;
        issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h8070_F0A5);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_resp_valid", 32'(bus.resp_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        rr_mode = 0;
        wait_drain();

        // SW accepted, then reset asserted while in WRITE.
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'hDEAD_BEEF;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("sw_we_in_write", 32'(bus.mem_we), 1);
        rst = 1'b1;
        #1;
        check("rstw_mem_we", 32'(bus.mem_we), 0);
        check("rstw_req_ready", 32'(bus.req_ready), 1);
        check("rstw_resp_valid", 32'(bus.resp_valid), 0);
        check("rstw_mem_addr", bus.mem_addr, 0);
        check("rstw_mem_wdata", bus.mem_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstw_no_write", dmem[16], init_word(16));
        issue(1'b0, 3'd2, 32'h40, 32'd0, 1'b1, init_word(16));
        wait_drain();

        rr_mode = 1;
        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, 32'd0);
        end
        wait_drain();
        rr_mode = 0;

        diffs = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) diffs++;
        check("mem_image_diffs", diffs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
